// File: rtl/debounce_bank.sv
// debounce_bank: independent per-channel button debouncers with press/release edge pulses and
// a one-shot long-press pulse. Define DEBOUNCE_BANK_SYNC_EN to add a 2-flop input synchroniser.
module debounce_bank #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned DELAY_VAL = 2500,
  parameter int unsigned HOLD_VAL  = 50000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press_edge,
  output logic [N_CH-1:0] release_edge,
  output logic [N_CH-1:0] long_press
);

  localparam int unsigned     CntW    = (DELAY_VAL < 1) ? 1 : $clog2(DELAY_VAL + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DELAY_VAL);
  localparam logic [31:0]     HoldMax = 32'(HOLD_VAL);
  localparam logic [31:0]     HoldPre = 32'(HOLD_VAL - 1);

  logic [N_CH-1:0] s;

`ifdef DEBOUNCE_BANK_SYNC_EN
  logic [N_CH-1:0] sync1_q;
  logic [N_CH-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = button;
`endif

  for (genvar g = 0; g < N_CH; g++) begin : gen_ch
    logic            cand_q;
    logic [CntW-1:0] cnt_q;
    logic            lvl_q;
    logic            lvl_dly_q;
    logic [31:0]     hcnt_q;
    logic            lp_q;

    // Any disagreement with the candidate restarts the stability window.
    always_ff @(posedge clk) begin
      if (reset) begin
        cand_q <= 1'b0;
        cnt_q  <= '0;
        lvl_q  <= 1'b0;
      end else if (s[g] != cand_q) begin
        cand_q <= s[g];
        cnt_q  <= '0;
      end else if (cnt_q == CntMax) begin
        lvl_q  <= cand_q;
      end else begin
        cnt_q  <= cnt_q + CntW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        lvl_dly_q <= 1'b0;
      end else begin
        lvl_dly_q <= lvl_q;
      end
    end

    // Pulse fires on the step into saturation, so it cannot repeat until level drops.
    always_ff @(posedge clk) begin
      if (reset || !lvl_q) begin
        hcnt_q <= '0;
        lp_q   <= 1'b0;
      end else begin
        lp_q <= (hcnt_q == HoldPre);
        if (hcnt_q < HoldMax) begin
          hcnt_q <= hcnt_q + 32'd1;
        end
      end
    end

    assign level[g]        = lvl_q;
    assign press_edge[g]   = lvl_q & ~lvl_dly_q;
    assign release_edge[g] = ~lvl_q & lvl_dly_q;
    assign long_press[g]   = lp_q;
  end

endmodule
